// File: rtl/mult_pkg.sv
// Shared types and elaboration limits for the iterative shift-add multiplier.
package mult_pkg;

    localparam int STATE_W   = 2;
    localparam int WIDTH_MIN = 4;
    localparam int WIDTH_MAX = 32;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        HOLD = 2'd3
    } state_t;

    function automatic bit width_ok(input int width, input int frac);
        return (width >= WIDTH_MIN) && (width <= WIDTH_MAX) && (frac >= 0) && (frac < width);
    endfunction

endpackage

// File: rtl/fx_saturate.sv
// Turns a full 2*WIDTH product into a WIDTH-bit fixed-point value: shift right by FRAC,
// then clamp to the signed or unsigned range of the result word.
module fx_saturate #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 0
) (
    input  logic [2*WIDTH-1:0] prod,
    input  logic               signed_mode,
    output logic [WIDTH-1:0]   fx,
    output logic               sat
);

    logic [2*WIDTH-1:0] shifted;

    // A signed value fits in WIDTH bits only when every bit above the result sign matches it.
    always_comb begin
        if (signed_mode) begin
            shifted = $signed(prod) >>> FRAC;
        end else begin
            shifted = prod >> FRAC;
        end
        fx  = shifted[WIDTH-1:0];
        sat = 1'b0;
        if (signed_mode) begin
            if (shifted[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){shifted[2*WIDTH-1]}}) begin
                sat = 1'b1;
                fx  = shifted[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            end
        end else if (shifted[2*WIDTH-1:WIDTH] != '0) begin
            sat = 1'b1;
            fx  = '1;
        end
    end

endmodule

// File: rtl/seq_mult_fx.sv
// Radix-2 shift-add multiplier on operand magnitudes; the sign is reapplied at the end,
// and both the full product and a saturated fixed-point result are delivered via valid/ready.
module seq_mult_fx
    import mult_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    input  logic               signed_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] prod_out,
    output logic [WIDTH-1:0]   fx_out,
    output logic               sat_out,
    output logic               busy
);

    localparam int CNT_W = 6;

    if (!width_ok(WIDTH, FRAC)) begin : g_bad_params
        $error("seq_mult_fx: WIDTH must be 4..32 and FRAC must be 0..WIDTH-1");
    end

    state_t             state;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_shift;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic               neg;
    logic               mode;

    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH:0]     partial;
    logic [2*WIDTH-1:0] final_prod;
    logic [WIDTH-1:0]   fx_val;
    logic               sat_val;

    // Negating -2^(WIDTH-1) wraps back to the same bit pattern, which read unsigned is exactly its magnitude.
    always_comb begin
        a_abs      = (signed_in && a_in[WIDTH-1]) ? (~a_in + WIDTH'(1)) : a_in;
        b_abs      = (signed_in && b_in[WIDTH-1]) ? (~b_in + WIDTH'(1)) : b_in;
        partial    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (b_shift[0] ? {1'b0, a_mag} : '0);
        final_prod = neg ? (~acc + (2*WIDTH)'(1)) : acc;
    end

    fx_saturate #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_fx_saturate (
        .prod        (final_prod),
        .signed_mode (mode),
        .fx          (fx_val),
        .sat         (sat_val)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            prod_out  <= '0;
            fx_out    <= '0;
            sat_out   <= 1'b0;
            a_mag     <= '0;
            b_shift   <= '0;
            acc       <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            mode      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_mag    <= a_abs;
                        b_shift  <= b_abs;
                        neg      <= signed_in & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
                        mode     <= signed_in;
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= CALC;
                    end
                end
                // The carry of each partial add becomes the top bit of the shifted accumulator.
                CALC: begin
                    acc     <= {partial, acc[WIDTH-1:1]};
                    b_shift <= b_shift >> 1;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    prod_out  <= final_prod;
                    fx_out    <= fx_val;
                    sat_out   <= sat_val;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
